// File: rtl/full_adder_bit.sv
// Single-bit full adder: the arithmetic primitive chained by full_adder_cell.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  // Propagate/generate form of the sum and carry.
  always_comb begin
    p    = a ^ b;
    sum  = p ^ cin;
    cout = (a & b) | (cin & p);
  end

endmodule

// File: rtl/full_adder_cell.sv
// Parameterised ripple-carry adder with an optional registered result stage
// carrying carry-out, signed-overflow, zero and valid flags.
module full_adder_cell #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             zero_q,
  output logic             valid_q
);

  logic msb_cin;
  logic ovf_d;
  logic zero_d;

  // Each stage keeps its own carry nets so the chain is a plain sequence of
  // single-bit signals rather than one vector feeding back into itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_bit[i-1].co;
    end
    full_adder_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (ci),
      .sum  (sum[i]),
      .cout (co)
    );
  end

  assign cout    = g_bit[WIDTH-1].co;
  assign msb_cin = g_bit[WIDTH-1].ci;

  // Flags derived from the combinational result for capture.
  always_comb begin
    ovf_d  = msb_cin ^ cout;
    zero_d = (sum == '0);
  end

  if (REG_OUT) begin : g_reg
    // Result register: async clear, capture on en, valid pulses per capture.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sum_q   <= '0;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
        zero_q  <= 1'b0;
        valid_q <= 1'b0;
      end else if (en) begin
        sum_q   <= sum;
        cout_q  <= cout;
        ovf_q   <= ovf_d;
        zero_q  <= zero_d;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end else begin : g_noreg
    assign sum_q   = '0;
    assign cout_q  = 1'b0;
    assign ovf_q   = 1'b0;
    assign zero_q  = 1'b0;
    assign valid_q = 1'b0;
  end

endmodule

// File: tb/tb_full_adder_cell.sv
// Directed bench for full_adder_cell at WIDTH=1 and WIDTH=8.
module tb_full_adder_cell;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       a1, b1, c1;
  logic       s1, co1, sq1, coq1, ovq1, zq1, vq1;
  logic [7:0] a8, b8;
  logic       c8;
  logic [7:0] s8, sq8;
  logic       co8, coq8, ovq8, zq8, vq8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  full_adder_cell #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .en(en), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .cout(co1), .sum_q(sq1), .cout_q(coq1), .ovf_q(ovq1),
    .zero_q(zq1), .valid_q(vq1)
  );

  full_adder_cell #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .reset_n(reset_n), .en(en), .a(a8), .b(b8), .cin(c8),
    .sum(s8), .cout(co8), .sum_q(sq8), .cout_q(coq8), .ovf_q(ovq8),
    .zero_q(zq8), .valid_q(vq8)
  );

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({sq1, coq1, ovq1, zq1, vq1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_w1 got=%b exp=00000", {sq1, coq1, ovq1, zq1, vq1});
    end
    checks++;
    if ({sq8, coq8, ovq8, zq8, vq8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_w8 got=%h exp=000", {sq8, coq8, ovq8, zq8, vq8});
    end
  endtask

  task automatic test_comb_w1();
    a1 = 0; b1 = 0; c1 = 0; #10;
    checks++;
    if ({co1, s1} !== 2'b00) begin
      errors++; $display("FAIL comb_000 got=%b exp=00", {co1, s1});
    end
    a1 = 1; b1 = 1; c1 = 0; #10;
    checks++;
    if ({co1, s1} !== 2'b10) begin
      errors++; $display("FAIL comb_110 got=%b exp=10", {co1, s1});
    end
    a1 = 1; b1 = 1; c1 = 1; #10;
    checks++;
    if ({co1, s1} !== 2'b11) begin
      errors++; $display("FAIL comb_111 got=%b exp=11", {co1, s1});
    end
  endtask

  task automatic test_sweep_w1();
    logic [1:0] exp;
    for (int v = 0; v < 8; v++) begin
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      #2;
      checks++;
      if ({co1, s1} !== exp) begin
        errors++; $display("FAIL sweep_%0d got=%b exp=%b", v, {co1, s1}, exp);
      end
    end
  endtask

  task automatic test_reset_hold();
    reset_n = 1'b0;
    en = 1'b1;
    a1 = 1; b1 = 0; c1 = 0;
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    edge_wait();
    checks++;
    if ({co1, s1} !== 2'b01) begin
      errors++; $display("FAIL rst_comb_w1 got=%b exp=01", {co1, s1});
    end
    checks++;
    if ({co8, s8} !== 9'h047) begin
      errors++; $display("FAIL rst_comb_w8 got=%h exp=047", {co8, s8});
    end
    a1 = 0; b1 = 1; c1 = 1;
    edge_wait();
    checks++;
    if ({co1, s1} !== 2'b10) begin
      errors++; $display("FAIL rst_comb2_w1 got=%b exp=10", {co1, s1});
    end
    checks++;
    if ({sq1, coq1, ovq1, zq1, vq1, sq8, coq8, ovq8, zq8, vq8} !== 17'h0) begin
      errors++; $display("FAIL rst_q_hold got=%h exp=0",
                         {sq1, coq1, ovq1, zq1, vq1, sq8, coq8, ovq8, zq8, vq8});
    end
  endtask

  task automatic test_capture_w1();
    en = 1'b0;
    #2 reset_n = 1'b1;
    #1;
    checks++;
    if ({sq1, coq1, ovq1, zq1, vq1} !== 5'b0) begin
      errors++; $display("FAIL release_nochange got=%b exp=00000", {sq1, coq1, ovq1, zq1, vq1});
    end
    edge_wait();
    a1 = 1; b1 = 1; c1 = 1; en = 1'b1;
    edge_wait();
    en = 1'b0;
    checks++;
    if ({sq1, coq1, ovq1, zq1, vq1} !== 5'b11001) begin
      errors++; $display("FAIL cap_w1 got=%b exp=11001", {sq1, coq1, ovq1, zq1, vq1});
    end
  endtask

  task automatic test_w8_wrap();
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; #2;
    checks++;
    if ({co8, s8} !== 9'h100) begin
      errors++; $display("FAIL wrap_comb got=%h exp=100", {co8, s8});
    end
    en = 1'b1;
    edge_wait();
    en = 1'b0;
    checks++;
    if ({sq8, coq8, ovq8, zq8, vq8} !== {8'h00, 4'b1011}) begin
      errors++; $display("FAIL wrap_q got=%h exp=00b", {sq8, coq8, ovq8, zq8, vq8});
    end
  endtask

  task automatic test_w8_ovf();
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; #2;
    checks++;
    if ({co8, s8} !== 9'h080) begin
      errors++; $display("FAIL ovf_comb got=%h exp=080", {co8, s8});
    end
    en = 1'b1;
    edge_wait();
    en = 1'b0;
    checks++;
    if ({sq8, coq8, ovq8, zq8, vq8} !== {8'h80, 4'b0101}) begin
      errors++; $display("FAIL ovf_q got=%h exp=805", {sq8, coq8, ovq8, zq8, vq8});
    end
  endtask

  task automatic test_hold();
    a8 = 8'h01; b8 = 8'h01; c8 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      edge_wait();
      checks++;
      if ({sq8, coq8, ovq8, zq8, vq8} !== {8'h80, 4'b0100}) begin
        errors++; $display("FAIL hold_%0d got=%h exp=804", k, {sq8, coq8, ovq8, zq8, vq8});
      end
    end
  endtask

  task automatic test_async_reset();
    a8 = 8'h05; b8 = 8'h03; c8 = 1'b0; en = 1'b1;
    edge_wait();
    checks++;
    if ({sq8, coq8, ovq8, zq8, vq8} !== {8'h08, 4'b0001}) begin
      errors++; $display("FAIL pre_rst got=%h exp=081", {sq8, coq8, ovq8, zq8, vq8});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({sq8, coq8, ovq8, zq8, vq8, sq1, coq1, ovq1, zq1, vq1} !== 17'h0) begin
      errors++; $display("FAIL async_clr got=%h exp=0",
                         {sq8, coq8, ovq8, zq8, vq8, sq1, coq1, ovq1, zq1, vq1});
    end
    edge_wait();
    checks++;
    if ({sq8, coq8, ovq8, zq8, vq8} !== 12'h000) begin
      errors++; $display("FAIL rst_discard got=%h exp=000", {sq8, coq8, ovq8, zq8, vq8});
    end
    en = 1'b0;
    #2 reset_n = 1'b1;
    edge_wait();
    checks++;
    if ({sq8, coq8, ovq8, zq8, vq8} !== 12'h000) begin
      errors++; $display("FAIL post_rst got=%h exp=000", {sq8, coq8, ovq8, zq8, vq8});
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    a1 = 0; b1 = 0; c1 = 0;
    a8 = '0; b8 = '0; c8 = 1'b0;
    test_reset();
    test_comb_w1();
    test_sweep_w1();
    test_reset_hold();
    test_capture_w1();
    test_w8_wrap();
    test_w8_ovf();
    test_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
